// File: rtl/npc_multicycle_sequencer.sv
// rtl/npc_multicycle_sequencer.sv - multi-cycle NPC sequencer: fetch/exec/mem/writeback with fault detection
// Optional cycle/instret counters are enabled by defining NPC_SEQ_PERF_EN.
module npc_multicycle_sequencer #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
   parameter int              MAX_WAIT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] pc,
   output logic            ifu_req_valid,
   output logic [XLEN-1:0] ifu_req_addr,
   input  logic            ifu_req_ready,
   input  logic            ifu_rsp_valid,
   input  logic [31:0]     ifu_rsp_inst,
   input  logic            ifu_rsp_err,
   output logic [31:0]     inst,
   output logic            inst_valid,
   input  logic            dec_mem_access,
   input  logic            dec_halt,
   input  logic [XLEN-1:0] npc,
   output logic            lsu_req_valid,
   input  logic            lsu_req_ready,
   input  logic            lsu_rsp_valid,
   input  logic            lsu_rsp_err,
   output logic            commit,
   output logic            halted,
   output logic            fault,
   output logic [1:0]      fault_cause,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
);

   localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

   typedef enum logic [2:0] {
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_EXEC,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_WB,
      S_HALT,
      S_FAULT
   } state_t;

   state_t         state;
   logic [WCW-1:0] wait_cnt;
   logic           npc_aligned;

   assign npc_aligned  = (npc[1:0] == 2'b00);
   assign ifu_req_addr = pc;
   // Commit is the only output that looks at EXU/IDU inputs; it must land in the same cycle they are valid.
   assign commit       = ((state == S_EXEC) && dec_halt) || ((state == S_WB) && npc_aligned);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_FETCH_REQ;
         pc            <= RESET_PC;
         inst          <= '0;
         ifu_req_valid <= 1'b0;
         inst_valid    <= 1'b0;
         lsu_req_valid <= 1'b0;
         halted        <= 1'b0;
         fault         <= 1'b0;
         fault_cause   <= 2'd0;
         wait_cnt      <= '0;
      end else begin
         inst_valid <= 1'b0;
         unique case (state)
            S_FETCH_REQ: begin
               // The first cycle after reset release only raises the request.
               ifu_req_valid <= 1'b1;
               if (ifu_req_valid && ifu_req_ready) begin
                  ifu_req_valid <= 1'b0;
                  wait_cnt      <= '0;
                  state         <= S_FETCH_WAIT;
               end
            end
            S_FETCH_WAIT: begin
               if (ifu_rsp_valid) begin
                  if (ifu_rsp_err) begin
                     fault       <= 1'b1;
                     fault_cause <= 2'd0;
                     state       <= S_FAULT;
                  end else begin
                     inst       <= ifu_rsp_inst;
                     inst_valid <= 1'b1;
                     state      <= S_EXEC;
                  end
               end else if (wait_cnt == WAIT_LIM) begin
                  fault       <= 1'b1;
                  fault_cause <= 2'd3;
                  state       <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_EXEC: begin
               if (dec_halt) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (dec_mem_access) begin
                  lsu_req_valid <= 1'b1;
                  state         <= S_MEM_REQ;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM_REQ: begin
               if (lsu_req_ready) begin
                  lsu_req_valid <= 1'b0;
                  wait_cnt      <= '0;
                  state         <= S_MEM_WAIT;
               end
            end
            S_MEM_WAIT: begin
               if (lsu_rsp_valid) begin
                  if (lsu_rsp_err) begin
                     fault       <= 1'b1;
                     fault_cause <= 2'd1;
                     state       <= S_FAULT;
                  end else begin
                     state <= S_WB;
                  end
               end else if (wait_cnt == WAIT_LIM) begin
                  fault       <= 1'b1;
                  fault_cause <= 2'd3;
                  state       <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WB: begin
               if (npc_aligned) begin
                  pc            <= npc;
                  ifu_req_valid <= 1'b1;
                  state         <= S_FETCH_REQ;
               end else begin
                  fault       <= 1'b1;
                  fault_cause <= 2'd2;
                  state       <= S_FAULT;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

`ifdef NPC_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (!halted && !fault) begin
            cycle_cnt <= cycle_cnt + 64'd1;
         end
         if (commit) begin
            instret_cnt <= instret_cnt + 64'd1;
         end
      end
   end
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_multicycle_sequencer.sv
// tb/tb_npc_multicycle_sequencer.sv - self-checking bench for npc_multicycle_sequencer
// Per-instruction latency model builds expected per-cycle outputs; honours NPC_SEQ_PERF_EN.
`timescale 1ns/1ps
module tb_npc_multicycle_sequencer;

   localparam int          MAX_WAIT = 255;
   localparam logic [31:0] RST_PC   = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc, ifu_req_addr, ifu_rsp_inst, inst, npc;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic        inst_valid, dec_mem_access, dec_halt;
   logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
   logic        commit, halted, fault;
   logic [1:0]  fault_cause;
   logic [63:0] cycle_cnt, instret_cnt;

   always #5 clk = ~clk;

   npc_multicycle_sequencer #(.XLEN(32), .RESET_PC(RST_PC), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc),
      .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
      .inst(inst), .inst_valid(inst_valid), .dec_mem_access(dec_mem_access), .dec_halt(dec_halt),
      .npc(npc), .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .commit(commit),
      .halted(halted), .fault(fault), .fault_cause(fault_cause),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        ireq, ival, lreq, commit, halted, fault;
      logic [1:0]  cause;
      logic [63:0] cyc, ret;
   } exp_t;

   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int          tb_cyc = 0;
   int          n_commit = 0;
   int          n_lreq = 0;

   logic [31:0] m_pc, m_inst;
   int          m_term;
   logic [1:0]  m_cause;
   logic [63:0] m_cyc, m_ret;
   bit          m_inrst, m_first;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) tb_cyc++;

   always @(negedge clk) begin : cmp
      exp_t e;
      if (commit === 1'b1) n_commit++;
      if (lsu_req_valid === 1'b1) n_lreq++;
      if (expq.size() != 0) begin
         e = expq.pop_front();
         chk("pc", 64'(pc), 64'(e.pc));
         chk("ifu_req_addr", 64'(ifu_req_addr), 64'(e.pc));
         chk("inst", 64'(inst), 64'(e.inst));
         chk("ifu_req_valid", 64'(ifu_req_valid), 64'(e.ireq));
         chk("inst_valid", 64'(inst_valid), 64'(e.ival));
         chk("lsu_req_valid", 64'(lsu_req_valid), 64'(e.lreq));
         chk("commit", 64'(commit), 64'(e.commit));
         chk("halted", 64'(halted), 64'(e.halted));
         chk("fault", 64'(fault), 64'(e.fault));
         chk("fault_cause", 64'(fault_cause), 64'(e.cause));
         chk("cycle_cnt", cycle_cnt, e.cyc);
         chk("instret_cnt", instret_cnt, e.ret);
      end
   end

   task automatic noise();
      ifu_req_ready  = 1'($urandom);
      ifu_rsp_valid  = 1'($urandom);
      ifu_rsp_inst   = $urandom;
      ifu_rsp_err    = 1'($urandom);
      dec_mem_access = 1'($urandom);
      dec_halt       = 1'($urandom);
      npc            = $urandom;
      lsu_req_ready  = 1'($urandom);
      lsu_rsp_valid  = 1'($urandom);
      lsu_rsp_err    = 1'($urandom);
   endtask

   // Queue what this cycle must show, then advance to just after the next rising edge.
   task automatic emit(input logic ireq, input logic ival, input logic lreq, input logic cm);
      exp_t e;
      e.pc = m_pc; e.inst = m_inst;
      e.ireq = ireq; e.ival = ival; e.lreq = lreq; e.commit = cm;
      e.halted = (m_term == 1); e.fault = (m_term == 2); e.cause = m_cause;
`ifdef NPC_SEQ_PERF_EN
      e.cyc = m_cyc; e.ret = m_ret;
`else
      e.cyc = 64'd0; e.ret = 64'd0;
`endif
      expq.push_back(e);
      if (!m_inrst && m_term == 0) m_cyc = m_cyc + 64'd1;
      if (cm) m_ret = m_ret + 64'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0; ifu_rsp_err = 0;
      dec_mem_access = 0; dec_halt = 0; npc = 0;
      lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
      #1;
      chk("rst_async_pc", 64'(pc), 64'h8000_0000);
      chk("rst_async_ifu_valid", 64'(ifu_req_valid), 64'd0);
      chk("rst_async_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_async_lsu_valid", 64'(lsu_req_valid), 64'd0);
      m_pc = RST_PC; m_inst = '0; m_term = 0; m_cause = 2'd0;
      m_cyc = '0; m_ret = '0; m_inrst = 1; m_first = 1;
      emit(0, 0, 0, 0);
      emit(0, 0, 0, 0);
      rst_n = 1'b1;
      m_inrst = 0;
   endtask

   // a: IFU ready delay, b: IFU response index in wait (<0 never), c/d: same for LSU.
   task automatic run_inst(input int a, input int b, input bit eif, input logic [31:0] iw,
                           input bit halt, input bit mem, input int c, input int d, input bit els,
                           input logic [31:0] npcv, input int abort_k, output bit aborted);
      aborted = 0;
      if (m_first) begin
         noise(); emit(0, 0, 0, 0); m_first = 0;
      end
      for (int k = 0; k <= a; k++) begin
         noise(); ifu_req_ready = (k == a); emit(1, 0, 0, 0);
      end
      for (int k = 0; k <= MAX_WAIT; k++) begin
         noise(); ifu_rsp_valid = (k == b);
         if (k == b) begin ifu_rsp_err = eif; ifu_rsp_inst = iw; end
         emit(0, 0, 0, 0);
         if (k == b) break;
      end
      if (b < 0 || b > MAX_WAIT) begin m_term = 2; m_cause = 2'd3; return; end
      if (eif) begin m_term = 2; m_cause = 2'd0; return; end
      m_inst = iw;
      noise(); dec_halt = halt; dec_mem_access = mem;
      emit(0, 1, 0, halt);
      if (halt) begin m_term = 1; return; end
      if (mem) begin
         for (int k = 0; k <= c; k++) begin
            noise(); lsu_req_ready = (k == c); emit(0, 0, 1, 0);
         end
         for (int k = 0; k <= MAX_WAIT; k++) begin
            if (k == abort_k) begin aborted = 1; return; end
            noise(); lsu_rsp_valid = (k == d);
            if (k == d) lsu_rsp_err = els;
            emit(0, 0, 0, 0);
            if (k == d) break;
         end
         if (d < 0 || d > MAX_WAIT) begin m_term = 2; m_cause = 2'd3; return; end
         if (els) begin m_term = 2; m_cause = 2'd1; return; end
      end
      noise(); npc = npcv;
      if (npcv[1:0] != 2'b00) begin
         emit(0, 0, 0, 0); m_term = 2; m_cause = 2'd2;
      end else begin
         emit(0, 0, 0, 1); m_pc = npcv;
      end
   endtask

   task automatic run_terminal(input int n);
      for (int k = 0; k < n; k++) begin
         noise(); emit(0, 0, 0, 0);
      end
   endtask

   task automatic run_good();
      bit ab;
      run_inst($urandom_range(0, 3), $urandom_range(0, 4), 0, $urandom, 0,
               ($urandom_range(0, 2) == 0), $urandom_range(0, 2), $urandom_range(0, 3), 0,
               m_pc + 32'd4, -1, ab);
   endtask

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      bit ab;
      int t0, c0, l0, kind;
      logic [31:0] iw;
      rst_n = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // Zero-wait addi stream.
      run_inst(0, 0, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      chk("t1_pc_after_first", 64'(pc), 64'h8000_0004);
      t0 = tb_cyc;
      run_inst(0, 0, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      chk("t1_latency", 64'(tb_cyc - t0), 64'd4);
      chk("t1_commits", 64'(n_commit), 64'd2);

      // Slow IFU: ready after 3, response after 5.
      c0 = n_commit;
      run_inst(3, 5, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      chk("t2_pc", 64'(pc), 64'h8000_000c);
      chk("t2_commits", 64'(n_commit - c0), 64'd1);

      // Response on the last permitted wait cycle beats the timeout.
      run_inst(0, MAX_WAIT, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      chk("t2_late_rsp_no_fault", 64'(fault), 64'd0);

      // Load, LSU answers on its second wait cycle.
      t0 = tb_cyc; l0 = n_lreq;
      run_inst(0, 0, 0, 32'h0000_a083, 0, 1, 0, 1, 0, m_pc + 32'd4, -1, ab);
      chk("t3_latency", 64'(tb_cyc - t0), 64'd7);
      chk("t3_lsu_pulses", 64'(n_lreq - l0), 64'd1);

      for (int i = 0; i < 120; i++) run_good();

      // IFU bus error at 0x80000008.
      do_reset();
      run_inst(0, 0, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      run_inst(0, 0, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      run_inst(1, 2, 1, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      run_terminal(20);
      chk("t4_fault", 64'(fault), 64'd1);
      chk("t4_cause", 64'(fault_cause), 64'd0);
      chk("t4_pc", 64'(pc), 64'h8000_0008);

      // Silent IFU.
      do_reset();
      run_inst(0, 0, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      t0 = tb_cyc;
      run_inst(0, -1, 0, 32'h0, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      chk("t4_timeout_len", 64'(tb_cyc - t0), 64'd257);
      run_terminal(5);
      chk("t4_timeout_cause", 64'(fault_cause), 64'd3);

      // Misaligned branch target.
      do_reset();
      run_inst(0, 0, 0, 32'h0010_0093, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      c0 = n_commit;
      run_inst(0, 0, 0, 32'h0e00_0063, 0, 0, 0, 0, 0, 32'h8000_0102, -1, ab);
      run_terminal(8);
      chk("t5_cause", 64'(fault_cause), 64'd2);
      chk("t5_no_commit", 64'(n_commit - c0), 64'd0);
      chk("t5_pc", 64'(pc), 64'h8000_0004);

      // ebreak.
      do_reset();
      c0 = n_commit;
      run_inst(0, 0, 0, 32'h0010_0073, 1, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      run_terminal(8);
      chk("t5_halted", 64'(halted), 64'd1);
      chk("t5_halt_commit", 64'(n_commit - c0), 64'd1);

      // Reset dropped in the middle of MEM_WAIT.
      do_reset();
      run_inst(0, 0, 0, 32'h0000_a083, 0, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      run_inst(0, 1, 0, 32'h0000_a083, 0, 1, 1, 10, 0, m_pc + 32'd4, 3, ab);
      chk("t6_aborted_in_mem_wait", 64'(ab), 64'd1);
      do_reset();

      // Ten instructions then halt.
      for (int i = 0; i < 10; i++) run_good();
      run_inst(0, 0, 0, 32'h0010_0073, 1, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
      run_terminal(10);
`ifdef NPC_SEQ_PERF_EN
      chk("t6_instret", instret_cnt, 64'd11);
`else
      chk("t6_instret", instret_cnt, 64'd0);
`endif

      // Random fault mix.
      for (int it = 0; it < 10; it++) begin
         do_reset();
         for (int j = 0; j < int'($urandom_range(1, 3)); j++) run_good();
         kind = $urandom_range(0, 4);
         iw = $urandom;
         case (kind)
            0: run_inst($urandom_range(0, 2), $urandom_range(0, 3), 1, iw, 0, 0, 0, 0, 0,
                        m_pc + 32'd4, -1, ab);
            1: run_inst(0, $urandom_range(0, 3), 0, iw, 0, 1, $urandom_range(0, 2),
                        $urandom_range(0, 3), 1, m_pc + 32'd4, -1, ab);
            2: run_inst(0, 0, 0, iw, 0, 1'($urandom), 0, 0, 0,
                        m_pc + 32'd4 + 32'($urandom_range(1, 3)), -1, ab);
            3: run_inst(0, 1, 0, iw, 1, 0, 0, 0, 0, m_pc + 32'd4, -1, ab);
            default: run_inst(0, 0, 0, iw, 0, 1, 0, -1, 0, m_pc + 32'd4, -1, ab);
         endcase
         run_terminal(6);
      end

      @(negedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
